sevenseg_scan_ctrl: RTL and testbench
=====================================

Name: sevenseg_scan_ctrl

Overview:
Parametrised multiplexed seven-segment scanner, successor to the fixed 8-digit driver used by the game tops. Drives NUM_DIGITS common-anode digits from a packed hex bus. Adds a per-scan coherent snapshot, leading-zero blanking, per-digit decimal points, a global enable and a scan-complete strobe. Instantiated beside the game core on the 100 MHz clock; score digits connect to it directly.

Parameters:
NUM_DIGITS, 8, number of digits scanned (legal 1..16)
REFRESH_DIV, 100000, clk cycles each digit is held (legal >= 2; benches use 4)

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  synchronous, active-high
enable  in  1  1 = display on; 0 = all anodes off, scanning continues
digits  in  4*NUM_DIGITS  hex digits; digit i = digits[4i+3:4i], digit 0 rightmost
dp_mask  in  NUM_DIGITS  bit i = 1 lights DP of digit i
blank_lz  in  1  1 = suppress leading zeros
AN  out  NUM_DIGITS  anodes, active-low, one-hot-low when lit
SEG  out  7  cathodes, active-low; SEG[0]=CA .. SEG[6]=CG
DP  out  1  decimal point cathode, active-low
scan_done  out  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset (synchronous, active-high, also mid-scan): prescale=0, idx=0, snapshot digits/dp/blank=0, AN=all 1, SEG=7'h7F, DP=1, scan_done=0.
- prescale counts 0..REFRESH_DIV-1 and wraps. At the wrap cycle idx advances: idx==NUM_DIGITS-1 wraps to 0, otherwise idx+1.
- Snapshot: on the cycle where prescale==REFRESH_DIV-1 and idx==NUM_DIGITS-1, latch digits, dp_mask and blank_lz. scan_done=1 on that same edge for exactly one cycle. Input changes between snapshots have no visible effect, so there is no tearing within a scan.
- Leading-zero blank is computed on the snapshot. Digit i is blanked if blank_lz_s=1, i>0, and every snapshot digit j>=i equals 0. Digit 0 is never blanked. A blanked digit keeps SEG=7'h7F, but its DP still follows dp_mask.
- Outputs are registered with 1-cycle latency from idx/snapshot. AN[idx]=0 and all other AN=1 when enable=1; all AN=1 when enable=0. SEG=decode(snapshot[idx]); DP=~dp_s[idx].
- Decode, SEG[6:0] active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- NUM_DIGITS=1: idx is constant 0, and the snapshot plus scan_done occur every REFRESH_DIV cycles.
- Counter widths are $clog2-sized. idx has a minimum width of 1.

Optional Feature:
BRIGHTNESS_PWM_EN:
- When defined, adds input brightness[3:0] and a free-running 4-bit pwm counter, reset to 0.
- The lit anode is asserted only when pwm_cnt < brightness or brightness==15.
- brightness=0 keeps the display dark. SEG/DP are unaffected.
- When undefined, the port and counter are absent and the display runs at full duty.

Test Plan:
1. NUM_DIGITS=8, REFRESH_DIV=4, reset held 3 cycles then released, enable=1 -> AN=FF through reset. After release AN steps FE,FD,FB,... every 4 cycles starting 1 cycle after reset deasserts. SEG=1000000 (all zeros in snapshot). scan_done pulses every 32 cycles.
2. digits=32'h0000_00A5, blank_lz=1, after one scan_done -> digit0 SEG=0010010, digit1 SEG=0001000, digits 2..7 SEG=1111111.
3. Same digits with blank_lz=0 -> digits 2..7 SEG=1000000. With dp_mask=8'h04 and blank_lz=1, digit2 shows DP=0 and SEG=1111111.
4. Change digits mid-scan from 32'h11111111 to 32'h22222222 -> remaining digits of that scan still show 1111001; 0100100 appears only after the next scan_done.
5. enable=0 mid-scan -> AN=FF from the next cycle while scan_done timing is unchanged. Assert reset mid-scan -> all outputs return to reset values on the next edge.
6. With BRIGHTNESS_PWM_EN defined:
   - brightness=4 -> lit anode low for 4 of every 16 cycles.
   - brightness=0 -> AN=FF.
   - brightness=15 -> 100% duty.

Source files
------------

// File: rtl/sevenseg_scan_ctrl_if.sv
// Display bundle for sevenseg_scan_ctrl: hex/dp/blank/enable towards the scanner, anode/cathode drive back.
// BRIGHTNESS_PWM_EN adds the 4-bit brightness input.
interface sevenseg_scan_ctrl_if #(
   parameter int NUM_DIGITS = 8
);
   logic                    enable;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]   dp_mask;
   logic                    blank_lz;
`ifdef BRIGHTNESS_PWM_EN
   logic [3:0]              brightness;
`endif
   logic [NUM_DIGITS-1:0]   AN;
   logic [6:0]              SEG;
   logic                    DP;
   logic                    scan_done;

   modport master (
`ifdef BRIGHTNESS_PWM_EN
      output brightness,
`endif
      output enable, digits, dp_mask, blank_lz,
      input  AN, SEG, DP, scan_done
   );

   modport slave (
`ifdef BRIGHTNESS_PWM_EN
      input  brightness,
`endif
      input  enable, digits, dp_mask, blank_lz,
      output AN, SEG, DP, scan_done
   );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scanner with per-scan snapshot and leading-zero blanking; outputs registered, 1 cycle
// after idx/snapshot, no backpressure. BRIGHTNESS_PWM_EN adds PWM anode dimming from bus.brightness.
module sevenseg_scan_ctrl #(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                 clk,
   input  logic                 reset,
   sevenseg_scan_ctrl_if.slave  bus
);
   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]           prescale_q, prescale_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] dig_s_q, dig_s_d;
   logic [NUM_DIGITS-1:0]   dp_s_q, dp_s_d;
   logic                    blank_s_q, blank_s_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic                    done_q, done_d;
   logic [NUM_DIGITS-1:0]   lz_blank;
   logic [3:0]              cur_dig;
   logic                    digit_wrap, scan_wrap, lit;
`ifdef BRIGHTNESS_PWM_EN
   logic [3:0]              pwm_q, pwm_d;
`endif

   function automatic logic [6:0] decode(input logic [3:0] h);
      case (h)
         4'h0: decode = 7'b1000000;
         4'h1: decode = 7'b1111001;
         4'h2: decode = 7'b0100100;
         4'h3: decode = 7'b0110000;
         4'h4: decode = 7'b0011001;
         4'h5: decode = 7'b0010010;
         4'h6: decode = 7'b0000010;
         4'h7: decode = 7'b1111000;
         4'h8: decode = 7'b0000000;
         4'h9: decode = 7'b0010000;
         4'hA: decode = 7'b0001000;
         4'hB: decode = 7'b0000011;
         4'hC: decode = 7'b1000110;
         4'hD: decode = 7'b0100001;
         4'hE: decode = 7'b0000110;
         default: decode = 7'b0001110;
      endcase
   endfunction

   assign cur_dig = dig_s_q[4*idx_q +: 4];

   // Walk down from the top digit; a digit is blanked while everything at or above it is zero.
   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      lz_blank = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run    = zero_run && (dig_s_q[4*i +: 4] == 4'h0);
         lz_blank[i] = blank_s_q && (i > 0) && zero_run;
      end
   end

   always_comb begin
      digit_wrap = (prescale_q == PRE_LAST);
      scan_wrap  = digit_wrap && (idx_q == IDX_LAST);
      prescale_d = digit_wrap ? '0 : prescale_q + 1'b1;
      idx_d      = idx_q;
      if (digit_wrap) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end

      dig_s_d   = dig_s_q;
      dp_s_d    = dp_s_q;
      blank_s_d = blank_s_q;
      if (scan_wrap) begin
         dig_s_d   = bus.digits;
         dp_s_d    = bus.dp_mask;
         blank_s_d = bus.blank_lz;
      end
      done_d = scan_wrap;

`ifdef BRIGHTNESS_PWM_EN
      pwm_d = pwm_q + 4'd1;
      lit   = bus.enable && ((pwm_q < bus.brightness) || (bus.brightness == 4'hF));
`else
      lit   = bus.enable;
`endif
      an_d = '1;
      if (lit) begin
         an_d[idx_q] = 1'b0;
      end
      seg_d = lz_blank[idx_q] ? 7'h7F : decode(cur_dig);
      dp_d  = ~dp_s_q[idx_q];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prescale_q <= '0;
         idx_q      <= '0;
         dig_s_q    <= '0;
         dp_s_q     <= '0;
         blank_s_q  <= 1'b0;
         an_q       <= '1;
         seg_q      <= 7'h7F;
         dp_q       <= 1'b1;
         done_q     <= 1'b0;
`ifdef BRIGHTNESS_PWM_EN
         pwm_q      <= 4'd0;
`endif
      end else begin
         prescale_q <= prescale_d;
         idx_q      <= idx_d;
         dig_s_q    <= dig_s_d;
         dp_s_q     <= dp_s_d;
         blank_s_q  <= blank_s_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         done_q     <= done_d;
`ifdef BRIGHTNESS_PWM_EN
         pwm_q      <= pwm_d;
`endif
      end
   end

   assign bus.AN        = an_q;
   assign bus.SEG       = seg_q;
   assign bus.DP        = dp_q;
   assign bus.scan_done = done_q;
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl (8 digits, 4-cycle refresh): vector table + expectation queue, then reset/enable/PWM corners.
module tb_sevenseg_scan_ctrl;
   localparam int ND = 8;
   localparam int RD = 4;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011;
   localparam logic [6:0] SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;
   localparam logic [6:0] SX = 7'b1111111;

   typedef struct {
      logic [31:0]      dig;
      logic [7:0]       dp;
      logic             blz;
      logic             en;
      logic [7:0][6:0]  seg;
   } vec_t;

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
   } obs_t;

   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_bad = 0;
   obs_t exp_q[$];
   vec_t vecs[9];

   sevenseg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

   sevenseg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, want);
      end
   endtask

   task automatic check_sb(input string name);
      obs_t a_o, e_o;
      a_o = '{an: bus.AN, seg: bus.SEG, dp: bus.DP};
      n_vec++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL %s: no expectation queued, got AN=%h SEG=%b DP=%b", name, a_o.an, a_o.seg, a_o.dp);
      end else begin
         e_o = exp_q.pop_front();
         if (a_o !== e_o) begin
            n_bad++;
            $display("FAIL %s: got AN=%h SEG=%b DP=%b, expected AN=%h SEG=%b DP=%b",
                     name, a_o.an, a_o.seg, a_o.dp, e_o.an, e_o.seg, e_o.dp);
         end
      end
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.scan_done && n < 200);
      if (!bus.scan_done) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s: scan_done timeout after %0d cycles, expected within 200", name, n);
      end
   endtask

   task automatic drive_vec(input vec_t v);
      obs_t e;
      bus.digits   = v.dig;
      bus.dp_mask  = v.dp;
      bus.blank_lz = v.blz;
      bus.enable   = v.en;
      for (int i = 0; i < ND; i++) begin
         e.an = 8'hFF;
         if (v.en) e.an[i] = 1'b0;
         e.seg = v.seg[i];
         e.dp  = ~v.dp[i];
         exp_q.push_back(e);
      end
   endtask

   initial begin
      int cnt;
      vecs[0] = '{dig: 32'h000000A5, dp: 8'h00, blz: 1'b1, en: 1'b1, seg: {SX, SX, SX, SX, SX, SX, SA, S5}};
      vecs[1] = '{dig: 32'h000000A5, dp: 8'h00, blz: 1'b0, en: 1'b1, seg: {S0, S0, S0, S0, S0, S0, SA, S5}};
      vecs[2] = '{dig: 32'h000000A5, dp: 8'h04, blz: 1'b1, en: 1'b1, seg: {SX, SX, SX, SX, SX, SX, SA, S5}};
      vecs[3] = '{dig: 32'h11111111, dp: 8'h00, blz: 1'b0, en: 1'b1, seg: {S1, S1, S1, S1, S1, S1, S1, S1}};
      vecs[4] = '{dig: 32'h22222222, dp: 8'h00, blz: 1'b1, en: 1'b1, seg: {S2, S2, S2, S2, S2, S2, S2, S2}};
      vecs[5] = '{dig: 32'h01234567, dp: 8'h81, blz: 1'b1, en: 1'b1, seg: {SX, S1, S2, S3, S4, S5, S6, S7}};
      vecs[6] = '{dig: 32'h89ABCDEF, dp: 8'hFF, blz: 1'b1, en: 1'b0, seg: {S8, S9, SA, SB, SC, SD, SE, SF}};
      vecs[7] = '{dig: 32'h00000000, dp: 8'h01, blz: 1'b1, en: 1'b1, seg: {SX, SX, SX, SX, SX, SX, SX, S0}};
      vecs[8] = '{dig: 32'h00F00000, dp: 8'h00, blz: 1'b1, en: 1'b1, seg: {SX, SX, SF, S0, S0, S0, S0, S0}};

      reset        = 1'b1;
      bus.enable   = 1'b1;
      bus.digits   = 32'h12345678;
      bus.dp_mask  = 8'h00;
      bus.blank_lz = 1'b1;
`ifdef BRIGHTNESS_PWM_EN
      bus.brightness = 4'hF;
`endif

      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("reset hold %0d", c), {15'd0, bus.AN, bus.SEG, bus.DP, bus.scan_done},
             {15'd0, 8'hFF, 7'h7F, 1'b1, 1'b0});
      end
      reset = 1'b0;

      // First scan runs on the cleared snapshot, whatever the inputs say.
      for (int n = 1; n <= 33; n++) begin
         @(negedge clk);
         if (n % 4 == 1 && n <= 29) begin
            chk($sformatf("first scan digit %0d", n / 4), {16'd0, bus.AN, bus.SEG, bus.DP},
                {16'd0, ~(8'h01 << (n / 4)), S0, 1'b1});
         end
         if (n >= 31) begin
            chk($sformatf("first scan_done n=%0d", n), {31'd0, bus.scan_done}, {31'd0, n == 32});
         end
      end

      // Halfway through each scan the inputs are scrambled; the display must not tear.
      for (int v = 0; v < 9; v++) begin
         drive_vec(vecs[v]);
         wait_done($sformatf("v%0d snapshot", v));
         @(negedge clk);
         for (int k = 0; k < ND; k++) begin
            if (k > 0) repeat (RD) @(negedge clk);
            check_sb($sformatf("v%0d digit %0d", v, k));
            if (k == 3) begin
               bus.digits   = ~vecs[v].dig;
               bus.dp_mask  = ~vecs[v].dp;
               bus.blank_lz = ~vecs[v].blz;
            end
         end
      end

      wait_done("enable seq snapshot");
      @(negedge clk);
      chk("enable on AN", {24'd0, bus.AN}, {24'd0, 8'hFE});
      bus.enable = 1'b0;
      @(negedge clk);
      chk("enable off AN", {24'd0, bus.AN}, {24'd0, 8'hFF});
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!bus.scan_done && cnt < 100);
      chk("scan_done spacing while disabled", cnt, 30);
      bus.enable = 1'b1;
      @(negedge clk);
      chk("enable restored AN", {24'd0, bus.AN}, {24'd0, 8'hFE});

      repeat (6) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid-scan reset", {15'd0, bus.AN, bus.SEG, bus.DP, bus.scan_done},
          {15'd0, 8'hFF, 7'h7F, 1'b1, 1'b0});
      reset = 1'b0;
      @(negedge clk);
      chk("after mid-scan reset", {16'd0, bus.AN, bus.SEG, bus.DP}, {16'd0, 8'hFE, S0, 1'b1});

`ifdef BRIGHTNESS_PWM_EN
      begin
         logic [3:0] br_tab[3];
         int         duty_tab[3];
         br_tab[0] = 4'd4;  duty_tab[0] = 4;
         br_tab[1] = 4'd0;  duty_tab[1] = 0;
         br_tab[2] = 4'd15; duty_tab[2] = 16;
         for (int b = 0; b < 3; b++) begin
            bus.brightness = br_tab[b];
            repeat (2) @(negedge clk);
            cnt = 0;
            for (int c = 0; c < 16; c++) begin
               @(negedge clk);
               if (bus.AN != 8'hFF) cnt++;
            end
            chk($sformatf("pwm duty brightness=%0d", br_tab[b]), cnt, duty_tab[b]);
         end
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
